// File: rtl/uart_imem_loader_pkg.sv
// Shared constants, state encodings and helpers for the UART instruction-memory loader.
package uart_imem_loader_pkg;

   localparam logic [7:0]  LOADER_SYNC     = 8'hA5;
   localparam int unsigned DEFAULT_CLK_DIV = 868;

   // Loader frame FSM
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_CNT_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_e;

   // Serial byte receiver FSM
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // A word count is usable when it is non-zero and fits in the memory
   function automatic logic count_ok(input logic [15:0] n, input int unsigned depth);
      return (n != 16'd0) && (32'(n) <= depth);
   endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
   import uart_imem_loader_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_ferr
);

   localparam int unsigned     CNT_W   = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

   logic             sync1_q, sync2_q, prev_q;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   // Synchronize rx and keep the previous sample for falling-edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Receiver state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state: start detect, half-bit recheck, then one sample per bit period
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               valid_d = sync2_q;
               ferr_d  = !sync2_q;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign byte_data  = shift_q;
   assign byte_valid = valid_q;
   assign byte_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Receives a sync/count/data/checksum frame over UART and writes it into imem,
// holding the CPU in reset until the checksum verifies.
module uart_imem_loader
   import uart_imem_loader_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
   parameter int unsigned ADDR_W  = 6
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rstn,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ferr;

   loader_state_e     state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        chk_q, chk_d;
   logic              we_q, we_d;
   logic              cpu_rstn_q, cpu_rstn_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              to_err;
   logic              last_word_c;

   uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk        (clk),
      .rstn       (rstn),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ferr  (byte_ferr)
   );

   // Current address holds the final word of the image
   assign last_word_c = (addr_q == ADDR_W'(n_q - 16'd1));

   // Loader state and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         addr_q     <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         chk_q      <= '0;
         we_q       <= 1'b0;
         cpu_rstn_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         chk_q      <= chk_d;
         we_q       <= we_d;
         cpu_rstn_q <= cpu_rstn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Frame parsing, word assembly, checksum and address stepping
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      chk_d      = chk_q;
      we_d       = 1'b0;
      cpu_rstn_d = cpu_rstn_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      to_err     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (byte_valid && byte_data == LOADER_SYNC) begin
               state_d    = ST_CNT_HI;
               cpu_rstn_d = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               addr_d     = '0;
               chk_d      = '0;
               idx_d      = '0;
            end
         end
         ST_CNT_HI: begin
            if (byte_ferr) begin
               to_err = 1'b1;
            end else if (byte_valid) begin
               n_d     = {byte_data, 8'h00};
               state_d = ST_CNT_LO;
            end
         end
         ST_CNT_LO: begin
            if (byte_ferr) begin
               to_err = 1'b1;
            end else if (byte_valid) begin
               n_d = {n_q[15:8], byte_data};
               if (count_ok(n_d, DEPTH)) state_d = ST_DATA;
               else                      to_err  = 1'b1;
            end
         end
         ST_DATA: begin
            if (byte_ferr) begin
               to_err = 1'b1;
            end else if (byte_valid) begin
               wdata_d[{idx_q, 3'b000} +: 8] = byte_data;
               chk_d = chk_q ^ byte_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) we_d = 1'b1;
            end else if (we_q) begin
               // Step after the strobe; the final word leaves the address at N-1
               if (last_word_c) state_d = ST_CHK;
               else             addr_d  = addr_q + ADDR_W'(1);
            end
         end
         ST_CHK: begin
            if (byte_ferr) begin
               to_err = 1'b1;
            end else if (byte_valid) begin
               if (byte_data == chk_q) begin
                  state_d    = ST_DONE;
                  cpu_rstn_d = 1'b1;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  to_err = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (to_err) begin
         state_d = ST_ERR;
         err_d   = 1'b1;
         busy_d  = 1'b0;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rstn   = cpu_rstn_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed and randomized frames checked against a byte-level frame model.
module tb_uart_imem_loader;

   localparam int unsigned DIV = 4;
   localparam int unsigned AW  = 6;

   logic          clk = 1'b0;
   logic          rstn;
   logic          rx;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rstn;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   uart_imem_loader #(.CLK_DIV(DIV), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx         (rx),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rstn   (cpu_rstn),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   int errors = 0;
   int checks = 0;

   // Observed write strobes and timing of byte_valid / cpu_rstn rise
   int            cyc = 0;
   int            bv_cyc = -100;
   int            rise_cyc = -200;
   logic          prev_cpu = 1'b0;
   logic          prev_we = 1'b0;
   bit            we_double = 1'b0;
   logic [AW-1:0] obs_addr[$];
   logic [31:0]   obs_data[$];

   always @(negedge clk) begin
      cyc++;
      if (dut.u_rx.byte_valid) bv_cyc = cyc;
      if (cpu_rstn && !prev_cpu) rise_cyc = cyc;
      if (imem_we) begin
         obs_addr.push_back(imem_addr);
         obs_data.push_back(imem_wdata);
         if (prev_we) we_double = 1'b1;
      end
      prev_cpu = cpu_rstn;
      prev_we  = imem_we;
   end

   // Reference model: tracks position within a frame and the expected writes
   bit            m_in = 1'b0;
   int            m_pos, m_n;
   logic [7:0]    m_x;
   logic [31:0]   m_w;
   bit            m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic [7:0]    tx_q[$];

   task automatic model_reset();
      m_in = 0; m_done = 0; m_err = 0; m_busy = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit stop);
      int p;
      if (!m_in) begin
         if (stop && b == 8'hA5) begin
            m_in = 1; m_pos = 0; m_x = 8'h00; m_n = 0;
            m_done = 0; m_err = 0; m_busy = 1;
         end
         return;
      end
      if (!stop) begin m_in = 0; m_err = 1; m_busy = 0; return; end
      m_pos++;
      if (m_pos == 1) begin
         m_n = int'(b) * 256;
      end else if (m_pos == 2) begin
         m_n += int'(b);
         if (m_n == 0 || m_n > 2 ** AW) begin m_in = 0; m_err = 1; m_busy = 0; end
      end else if (m_pos < 3 + 4 * m_n) begin
         p = m_pos - 3;
         m_w[8 * (p % 4) +: 8] = b;
         m_x ^= b;
         if (p % 4 == 3) begin
            exp_addr.push_back(AW'(p / 4));
            exp_data.push_back(m_w);
         end
      end else begin
         m_in = 0; m_busy = 0;
         if (b == m_x) m_done = 1; else m_err = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      model_byte(b, stop);
   endtask

   task automatic send_q();
      for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
      tx_q.delete();
   endtask

   task automatic load_good_frame();
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
   endtask

   task automatic check_frame(input string tag);
      int n;
      repeat (4) @(negedge clk);
      chk({tag, "_nwr"}, 64'(obs_data.size()), 64'(exp_data.size()));
      n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
         chk({tag, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
      end
      chk({tag, "_done"}, 64'(done), 64'(m_done));
      chk({tag, "_err"}, 64'(err), 64'(m_err));
      chk({tag, "_cpu_rstn"}, 64'(cpu_rstn), 64'(m_done));
      chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
      chk({tag, "_single_strobe"}, 64'(we_double), 64'd0);
      if (m_done) chk({tag, "_rise_delay"}, 64'(rise_cyc - bv_cyc), 64'd1);
      obs_addr.delete(); obs_data.delete();
      exp_addr.delete(); exp_data.delete();
      we_double = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"}, 64'(imem_we), 64'd0);
      chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
      chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
      chk({tag, "_cpu_rstn"}, 64'(cpu_rstn), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b, x;
      int         n, k;

      // Reset and idle line
      rstn = 1'b0; rx = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rstn = 1'b1;
      repeat (200) @(negedge clk);
      chk_reset_vals("idle");
      check_frame("idle");

      // Good two-word frame
      load_good_frame();
      send_q();
      chk("t2_w0", 64'(obs_data.size() > 0 ? obs_data[0] : 32'hxxxx_xxxx), 64'h0050_0093);
      chk("t2_w1", 64'(obs_data.size() > 1 ? obs_data[1] : 32'hxxxx_xxxx), 64'h0010_0113);
      check_frame("t2");
      chk("t2_done_const", 64'(done), 64'd1);

      // Bad checksum, then recovery
      load_good_frame();
      tx_q[11] = 8'hC0;
      send_q();
      check_frame("t3_bad");
      chk("t3_err_const", 64'(err), 64'd1);
      load_good_frame();
      send_q();
      check_frame("t3_good");

      // Leading junk bytes ignored
      tx_q = '{8'h00, 8'hFF, 8'h5A};
      send_q();
      load_good_frame();
      send_q();
      check_frame("t4");

      // Out-of-range and zero counts
      tx_q = '{8'hA5, 8'h00, 8'h41};
      send_q();
      check_frame("t5_big");
      tx_q = '{8'hA5, 8'h00, 8'h00};
      send_q();
      check_frame("t5_zero");

      // Framing error on the third data byte
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
      send_q();
      send_byte(8'h33, 1'b0);
      check_frame("t6_ferr");
      chk("t6_err_const", 64'(err), 64'd1);

      // Reset mid-DATA after one word
      tx_q = '{8'hA5, 8'h00, 8'h02};
      for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      send_q();
      chk("t6_busy_mid", 64'(busy), 64'(m_busy));
      chk("t6_nwr_mid", 64'(obs_data.size()), 64'(exp_data.size()));
      if (obs_data.size() > 0 && exp_data.size() > 0)
         chk("t6_data_mid", 64'(obs_data[0]), 64'(exp_data[0]));
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk_reset_vals("t6_rstn");
      model_reset();
      obs_addr.delete(); obs_data.delete();
      exp_addr.delete(); exp_data.delete();
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      load_good_frame();
      send_q();
      check_frame("t6_recover");

      // Randomized frames with junk prefixes and occasional bad checksums
      for (int it = 0; it < 6; it++) begin
         k = $urandom_range(0, 2);
         for (int j = 0; j < k; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            tx_q.push_back(b);
         end
         n = $urandom_range(1, 4);
         tx_q.push_back(8'hA5);
         tx_q.push_back(8'(n / 256));
         tx_q.push_back(8'(n % 256));
         x = 8'h00;
         for (int j = 0; j < 4 * n; j++) begin
            b = 8'($urandom_range(0, 255));
            x ^= b;
            tx_q.push_back(b);
         end
         if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
         tx_q.push_back(x);
         send_q();
         check_frame("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
